// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and sizes for the truth table scanner
package scan_pkg;

  localparam int VEC_W = 5;
  localparam int N_VEC = 32;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

  // busy covers the settle and sample phases only; DONE is not busy
  function automatic logic is_busy(input scan_state_e s);
    return (s == ST_WAIT) || (s == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable settle countdown with combinational expire
module settle_timer
  import scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load wins; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = count_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // expire is decoded from the current count so the FSM reacts in the same cycle
  assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - exhaustive 5-input truth table capture and compare
module truth_table_scanner
  import scan_pkg::*;
#(
  parameter int unsigned       SETTLE   = 2,
  parameter logic [N_VEC-1:0]  EXPECTED = 32'hA2A02255
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  output logic [VEC_W-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_q,
  output logic [5:0]       mismatch_cnt,
  output logic             pass
);

  localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(N_VEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE);

  scan_state_e      state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [N_VEC-1:0] tbl_q, tbl_d;
  logic [5:0]       mis_q, mis_d;
  logic             pass_q, pass_d;

  logic             expire;
  logic             load;
  logic             clear;
  logic             sample_en;
  logic             finish;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .count_i  (SETTLE_VAL),
    .expire_o (expire)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: abort only matters while busy, start only in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort)       state_d = ST_IDLE;
        else if (expire) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)                  state_d = ST_IDLE;
        else if (vec_q == LAST_VEC) state_d = ST_DONE;
        else                        state_d = ST_WAIT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    busy      = is_busy(state_q);
    done      = (state_q == ST_DONE);
    clear     = (state_q == ST_IDLE) && start;
    sample_en = (state_q == ST_SAMPLE) && !abort;
    load      = clear || (sample_en && (vec_q != LAST_VEC));
    finish    = (state_q == ST_DONE);
  end

  // datapath next state: clear on accepted start, capture and compare on sample
  always_comb begin
    vec_d  = vec_q;
    tbl_d  = tbl_q;
    mis_d  = mis_q;
    pass_d = pass_q;
    if (clear) begin
      vec_d  = '0;
      tbl_d  = '0;
      mis_d  = '0;
      pass_d = 1'b0;
    end
    if (sample_en) begin
      tbl_d[vec_q] = dut_out;
      if (dut_out != EXPECTED[vec_q]) begin
        mis_d = mis_q + 6'd1;
      end
      if (vec_q != LAST_VEC) begin
        vec_d = vec_q + VEC_W'(1);
      end
    end
    if (finish) begin
      pass_d = (mis_q == 6'd0);
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q  <= '0;
      tbl_q  <= '0;
      mis_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      tbl_q  <= tbl_d;
      mis_q  <= mis_d;
      pass_q <= pass_d;
    end
  end

  assign vec          = vec_q;
  assign table_q      = tbl_q;
  assign mismatch_cnt = mis_q;
  assign pass         = pass_q;

endmodule
